// File: rtl/pong_pkg.sv
// Shared constants, encoder phase encodings and paddle position helpers for the
// pong game blocks.
package pong_pkg;

    localparam int SCREEN_HEIGHT = 480;
    localparam int PADDLE_HEIGHT = 64;
    localparam int POS_W         = 10;

    localparam logic [POS_W-1:0] POS_MIN_DEFAULT   = 10'd0;
    localparam logic [POS_W-1:0] POS_MAX_DEFAULT   = POS_W'(SCREEN_HEIGHT - PADDLE_HEIGHT);
    localparam logic [POS_W-1:0] POS_RESET_DEFAULT = 10'd208;

    // Encoder phases as {A,B}; the clockwise order is DET00 -> PH10 -> PH11 -> PH01.
    typedef enum logic [1:0] {
        DET00 = 2'b00,
        PH01  = 2'b01,
        PH10  = 2'b10,
        PH11  = 2'b11
    } enc_state_t;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } dec_state_t;

    function automatic logic [POS_W-1:0] step_up(
        input logic [POS_W-1:0] pos,
        input logic [POS_W:0]   step,
        input logic [POS_W-1:0] max_pos
    );
        logic [POS_W:0] sum;
        sum = {1'b0, pos} + step;
        return (sum > {1'b0, max_pos}) ? max_pos : sum[POS_W-1:0];
    endfunction

    // Compare before subtracting so an underflow can never wrap past the floor.
    function automatic logic [POS_W-1:0] step_down(
        input logic [POS_W-1:0] pos,
        input logic [POS_W:0]   step,
        input logic [POS_W-1:0] min_pos
    );
        if ({1'b0, pos} >= step + {1'b0, min_pos})
            return pos - step[POS_W-1:0];
        return min_pos;
    endfunction

endpackage

// File: rtl/quad_debounce.sv
// Two-flop synchroniser and level debouncer for one raw encoder channel; also
// reports when the channel has been quiet long enough to trust its level.
module quad_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic settled
);

    localparam int                CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] bounce_cnt;
    logic [CNT_W-1:0] settle_cnt;

    // NOTE: every register here uses <= so all flops sample pre-edge values,
    // which is what makes sync1 -> sync2 a real two-stage pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            bounce_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != level) begin
                settle_cnt <= '0;
                if (bounce_cnt == LAST) begin
                    level      <= sync2;
                    bounce_cnt <= '0;
                end else begin
                    bounce_cnt <= bounce_cnt + 1'b1;
                end
            end else begin
                bounce_cnt <= '0;
                // A change still inside the synchroniser must not count as quiet time.
                if (sync1 != level)
                    settle_cnt <= '0;
                else if (settle_cnt != FULL)
                    settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    assign settled = (settle_cnt == FULL);

endmodule

// File: rtl/rotary_paddle_decoder.sv
// Quadrature encoder decoder: debounces both encoder lines, turns detent entries
// into paddle steps and publishes the saturated position once per frame.
module rotary_paddle_decoder
    import pong_pkg::*;
#(
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               STEP_PIXELS     = 8,
    parameter logic [POS_W-1:0] POS_MIN         = POS_MIN_DEFAULT,
    parameter logic [POS_W-1:0] POS_MAX         = POS_MAX_DEFAULT,
    parameter logic [POS_W-1:0] POS_RESET       = POS_RESET_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             rota,
    input  logic             rotb,
    input  logic             FrameStart,
    output logic [POS_W-1:0] PaddlePos,
    output logic             Step,
    output logic             Dir,
    output logic             IllegalEvt
);

    localparam logic [POS_W:0] STEP_W = (POS_W + 1)'(STEP_PIXELS);

    logic a_level, b_level, a_settled, b_settled;

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk     (Clock),
        .reset   (Reset),
        .raw     (rota),
        .level   (a_level),
        .settled (a_settled)
    );

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk     (Clock),
        .reset   (Reset),
        .raw     (rotb),
        .level   (b_level),
        .settled (b_settled)
    );

    dec_state_t       state, state_nx;
    enc_state_t       prev, prev_nx, cur;
    logic [POS_W-1:0] target, target_nx;
    logic             step_nx, dir_nx, illegal_nx;

    assign cur = enc_state_t'({a_level, b_level});

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_nx   = state;
        prev_nx    = prev;
        target_nx  = target;
        step_nx    = 1'b0;
        dir_nx     = Dir;
        illegal_nx = 1'b0;
        case (state)
            INIT: begin
                if (a_settled && b_settled) begin
                    prev_nx  = cur;
                    state_nx = TRACK;
                end
            end
            TRACK: begin
                prev_nx = cur;
                if ((cur ^ prev) == 2'b11) begin
                    illegal_nx = 1'b1;
                end else if (cur == DET00 && prev == PH01) begin
                    step_nx   = 1'b1;
                    dir_nx    = 1'b1;
                    target_nx = step_up(target, STEP_W, POS_MAX);
                end else if (cur == DET00 && prev == PH10) begin
                    step_nx   = 1'b1;
                    dir_nx    = 1'b0;
                    target_nx = step_down(target, STEP_W, POS_MIN);
                end
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= INIT;
            prev       <= DET00;
            target     <= POS_RESET;
            PaddlePos  <= POS_RESET;
            Step       <= 1'b0;
            Dir        <= 1'b0;
            IllegalEvt <= 1'b0;
        end else begin
            state      <= state_nx;
            prev       <= prev_nx;
            target     <= target_nx;
            Step       <= step_nx;
            Dir        <= dir_nx;
            IllegalEvt <= illegal_nx;
            // Publishes the pre-edge target, so a coincident step waits a frame.
            if (FrameStart)
                PaddlePos <= target;
        end
    end

endmodule

// File: tb/tb_rotary_paddle_decoder.sv
// Scoreboard bench for rotary_paddle_decoder: a phase-walk model predicts each
// Step/IllegalEvt pulse and the frame-published position.
module tb_rotary_paddle_decoder;

    localparam int DEB  = 4;
    localparam int STEP = 8;
    localparam int PMIN = 0;
    localparam int PMAX = 416;
    localparam int PRST = 208;
    localparam int LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rota = 1'b0;
    logic       rotb = 1'b0;
    logic       frame = 1'b0;
    logic [9:0] pos;
    logic       step, dir, illegal;

    always #5 clk = ~clk;

    rotary_paddle_decoder #(
        .DEBOUNCE_CYCLES (DEB),
        .STEP_PIXELS     (STEP)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .rota       (rota),
        .rotb       (rotb),
        .FrameStart (frame),
        .PaddlePos  (pos),
        .Step       (step),
        .Dir        (dir),
        .IllegalEvt (illegal)
    );

    typedef struct {
        bit is_illegal;
        bit cw;
        int cycle;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    // Reference model: current encoder phase and the paddle target in plain integers.
    logic [1:0] phase = 2'b00;
    int         target = PRST;
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idx(input logic [1:0] p);
        int r;
        r = 0;
        for (int i = 0; i < 4; i++)
            if (seq[i] == p) r = i;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && (step || illegal)) begin
            check("event expected by scoreboard", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                check("IllegalEvt", int'(illegal), int'(got.is_illegal));
                check("Step", int'(step), int'(!got.is_illegal));
                if (!got.is_illegal) check("Dir", int'(dir), int'(got.cw));
                check("event cycle", cyc, got.cycle);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Moves the encoder to phase p; the model classifies the move by its distance
    // around the clockwise ring of four phases.
    task automatic drive_phase(input logic [1:0] p, input int hold);
        int   d;
        exp_t e;
        d = (idx(p) - idx(phase) + 4) % 4;
        if (d == 2) begin
            e.is_illegal = 1'b1;
            e.cw         = 1'b0;
            e.cycle      = cyc + LAT;
            sb.push_back(e);
        end else if (d != 0 && p == 2'b00) begin
            e.is_illegal = 1'b0;
            e.cw         = (d == 1);
            e.cycle      = cyc + LAT;
            sb.push_back(e);
            if (d == 1) target = (target + STEP > PMAX) ? PMAX : target + STEP;
            else        target = (target - STEP >= PMIN) ? target - STEP : PMIN;
        end
        phase = p;
        {rota, rotb} = p;
        repeat (hold) tick();
    endtask

    task automatic detent(input bit cw);
        for (int i = 1; i <= 4; i++)
            drive_phase(seq[cw ? i % 4 : (4 - i) % 4], 10);
    endtask

    task automatic glitch(input int len, input bit on_b);
        if (on_b) rotb = ~phase[0];
        else      rota = ~phase[1];
        repeat (len) tick();
        {rota, rotb} = phase;
        repeat (12) tick();
    endtask

    task automatic frame_check(input string name);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check(name, int'(pos), target);
    endtask

    task automatic apply_reset(input logic [1:0] p);
        check("scoreboard drained before reset", sb.size(), 0);
        {rota, rotb} = p;
        rst = 1'b1;
        tick();
        check("reset PaddlePos", int'(pos), PRST);
        check("reset Step", int'(step), 0);
        check("reset Dir", int'(dir), 0);
        check("reset IllegalEvt", int'(illegal), 0);
        rst    = 1'b0;
        phase  = p;
        target = PRST;
        repeat (20) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r;
        int   old;

        // Reset with both channels high; INIT must exit silently.
        apply_reset(2'b11);
        frame_check("pos after reset at 11");

        // One clockwise detent; the step lands exactly LAT edges after the last phase.
        apply_reset(2'b00);
        drive_phase(2'b10, 10);
        drive_phase(2'b11, 10);
        drive_phase(2'b01, 10);
        drive_phase(2'b00, 10);
        check("pos held until frame", int'(pos), PRST);
        frame_check("pos after one cw detent");

        // Short glitches on either channel at a detent are invisible.
        glitch(2, 1'b0);
        glitch(DEB - 1, 1'b1);
        frame_check("pos after glitches");

        // Saturation at both ends, starting from the reset position.
        apply_reset(2'b00);
        for (int i = 0; i < 26; i++) detent(1'b1);
        frame_check("pos at upper bound");
        for (int i = 0; i < 4; i++) detent(1'b1);
        frame_check("pos saturated high");
        for (int i = 0; i < 52; i++) detent(1'b0);
        frame_check("pos at lower bound");
        for (int i = 0; i < 8; i++) detent(1'b0);
        frame_check("pos saturated low");

        // Double-bit jump is illegal; the rest of the rotation still steps.
        drive_phase(2'b11, 10);
        drive_phase(2'b01, 10);
        drive_phase(2'b00, 10);
        frame_check("pos after illegal then cw");

        // Random walk with occasional illegal jumps and glitches.
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      drive_phase(phase ^ 2'b11, $urandom_range(10, 20));
            else if (r <= 5) drive_phase(seq[(idx(phase) + 1) % 4], $urandom_range(10, 20));
            else if (r <= 8) drive_phase(seq[(idx(phase) + 3) % 4], $urandom_range(10, 20));
            else             glitch($urandom_range(1, DEB - 1), 1'($urandom_range(0, 1)));
            if (n % 16 == 15) frame_check("pos during random walk");
        end

        // Bring the encoder to 01 so the next entry to 00 is a clockwise step.
        while (phase != 2'b01) drive_phase(seq[(idx(phase) + 1) % 4], 10);

        // Step and FrameStart on the same edge: the old target is published.
        old = target;
        drive_phase(2'b00, LAT - 1);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        check("coincident frame keeps old pos", int'(pos), old);
        repeat (5) tick();
        frame_check("pos one frame after coincidence");

        // Reset in the middle of a debounce: no step may leak out afterwards.
        {rota, rotb} = 2'b10;
        repeat (3) tick();
        apply_reset(2'b10);
        repeat (20) tick();
        frame_check("pos after mid-phase reset");
        drive_phase(2'b00, 12);
        frame_check("pos after ccw step post-reset");

        check("scoreboard drained at end", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
